// File: rtl/system_timer_mc.sv
// Multi-channel interval timer on an Avalon-MM slave: per-channel down-counter with
// 8-bit prescaler, one-shot/continuous mode, snapshot capture and a combined interrupt.
module system_timer_mc #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned COUNT_W        = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned DEFAULT_PERIOD = 49999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec,
    output logic [NUM_CH-1:0] timeout_pulse
);

    localparam int unsigned CH_W = ADDR_W - 2;
    localparam logic [COUNT_W-1:0] RST_PERIOD = COUNT_W'(DEFAULT_PERIOD);

    logic [COUNT_W-1:0] r_count  [NUM_CH];
    logic [COUNT_W-1:0] r_period [NUM_CH];
    logic [COUNT_W-1:0] r_snap   [NUM_CH];
    logic [7:0]         r_ps     [NUM_CH];
    logic [7:0]         r_ps_cnt [NUM_CH];
    logic [NUM_CH-1:0]  r_to, r_run, r_ito, r_cont, r_pulse;
    logic [DATA_W-1:0]  r_rdata;

    logic [COUNT_W-1:0] w_count_nxt  [NUM_CH];
    logic [COUNT_W-1:0] w_period_nxt [NUM_CH];
    logic [COUNT_W-1:0] w_snap_nxt   [NUM_CH];
    logic [7:0]         w_ps_nxt     [NUM_CH];
    logic [7:0]         w_ps_cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0]  w_to_nxt, w_run_nxt, w_ito_nxt, w_cont_nxt;
    logic [NUM_CH-1:0]  w_tick, w_event;
    logic [DATA_W-1:0]  w_rdata;

    logic [CH_W-1:0] w_ch;
    logic [1:0]      w_off;
    logic            w_wr;
    logic            w_unused;

    assign w_ch     = address[ADDR_W-1:2];
    assign w_off    = address[1:0];
    assign w_wr     = chipselect & ~write_n;
    assign w_unused = &{1'b0, writedata};

    always_comb begin
        w_count_nxt  = r_count;
        w_period_nxt = r_period;
        w_snap_nxt   = r_snap;
        w_ps_nxt     = r_ps;
        w_ps_cnt_nxt = r_ps_cnt;
        w_to_nxt     = r_to;
        w_run_nxt    = r_run;
        w_ito_nxt    = r_ito;
        w_cont_nxt   = r_cont;
        w_tick       = '0;
        w_event      = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            w_tick[i] = r_run[i] && (r_ps_cnt[i] == r_ps[i]);
            if (r_run[i]) begin
                w_ps_cnt_nxt[i] = w_tick[i] ? 8'd0 : r_ps_cnt[i] + 8'd1;
            end
            if (w_tick[i]) begin
                if (r_count[i] == '0) begin
                    w_count_nxt[i] = r_period[i];
                    w_to_nxt[i]    = 1'b1;
                    w_event[i]     = 1'b1;
                    if (!r_cont[i]) w_run_nxt[i] = 1'b0;
                end else begin
                    w_count_nxt[i] = r_count[i] - COUNT_W'(1);
                end
            end
            // Bus writes override counting, except a coinciding timeout keeps TO set.
            if (w_wr && int'(w_ch) == i) begin
                case (w_off)
                    2'd0: if (!w_event[i]) w_to_nxt[i] = 1'b0;
                    2'd1: begin
                        w_ito_nxt[i]  = writedata[0];
                        w_cont_nxt[i] = writedata[1];
                        w_ps_nxt[i]   = writedata[15:8];
                        if (writedata[3]) begin
                            w_run_nxt[i] = 1'b0;
                        end else if (writedata[2] && !r_run[i]) begin
                            w_run_nxt[i]    = 1'b1;
                            w_ps_cnt_nxt[i] = 8'd0;
                        end
                    end
                    2'd2: begin
                        w_period_nxt[i] = writedata[COUNT_W-1:0];
                        w_count_nxt[i]  = writedata[COUNT_W-1:0];
                        w_run_nxt[i]    = 1'b0;
                        w_ps_cnt_nxt[i] = 8'd0;
                    end
                    default: w_snap_nxt[i] = r_count[i];
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (int'(w_ch) == i) begin
                case (w_off)
                    2'd0: w_rdata[1:0] = {r_run[i], r_to[i]};
                    2'd1: begin
                        w_rdata[0]    = r_ito[i];
                        w_rdata[1]    = r_cont[i];
                        w_rdata[15:8] = r_ps[i];
                    end
                    2'd2:    w_rdata[COUNT_W-1:0] = r_period[i];
                    default: w_rdata[COUNT_W-1:0] = r_snap[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                r_count[i]  <= RST_PERIOD;
                r_period[i] <= RST_PERIOD;
                r_snap[i]   <= '0;
                r_ps[i]     <= 8'd0;
                r_ps_cnt[i] <= 8'd0;
            end
            r_to    <= '0;
            r_run   <= '0;
            r_ito   <= '0;
            r_cont  <= '0;
            r_pulse <= '0;
            r_rdata <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_period <= w_period_nxt;
            r_snap   <= w_snap_nxt;
            r_ps     <= w_ps_nxt;
            r_ps_cnt <= w_ps_cnt_nxt;
            r_to     <= w_to_nxt;
            r_run    <= w_run_nxt;
            r_ito    <= w_ito_nxt;
            r_cont   <= w_cont_nxt;
            r_pulse  <= w_event;
            r_rdata  <= w_rdata;
        end
    end

    assign readdata      = r_rdata;
    assign irq_vec       = r_to & r_ito;
    assign irq           = |irq_vec;
    assign timeout_pulse = r_pulse;

endmodule

// File: tb/tb_system_timer_mc.sv
// Self-checking bench for system_timer_mc: directed scenarios plus randomized bus traffic
// checked against a per-channel behavioural model.
module tb_system_timer_mc;

    localparam int NCH = 3;
    localparam int CW  = 16;
    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int DEF = 49999;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          chipselect;
    logic          write_n;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          irq;
    logic [NCH-1:0] irq_vec;
    logic [NCH-1:0] timeout_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    system_timer_mc #(
        .NUM_CH(NCH), .COUNT_W(CW), .DATA_W(DW), .ADDR_W(AW), .DEFAULT_PERIOD(DEF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write_n(write_n),
        .address(address), .writedata(writedata), .readdata(readdata), .irq(irq),
        .irq_vec(irq_vec), .timeout_pulse(timeout_pulse)
    );

    // Behavioural model: one clock of the timer described by its register rules.
    int unsigned m_cnt[NCH], m_per[NCH], m_ps[NCH], m_psc[NCH], m_snap[NCH];
    bit m_run[NCH], m_to[NCH], m_ito[NCH], m_cont[NCH], m_pulse[NCH];
    logic [31:0] m_rdata;

    function automatic void model_step(bit rn, bit wr, logic [3:0] a, logic [31:0] d);
        int unsigned old_cnt[NCH];
        bit old_run[NCH];
        bit ev[NCH];
        int ch;
        if (!rn) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = DEF; m_per[c] = DEF; m_ps[c] = 0; m_psc[c] = 0; m_snap[c] = 0;
                m_run[c] = 0; m_to[c] = 0; m_ito[c] = 0; m_cont[c] = 0; m_pulse[c] = 0;
            end
            m_rdata = 0;
            return;
        end
        ch = int'(a[3:2]);
        m_rdata = 0;
        if (ch < NCH) begin
            case (a[1:0])
                2'd0: m_rdata = 32'(m_to[ch]) + 32'(m_run[ch]) * 2;
                2'd1: m_rdata = 32'(m_ito[ch]) + 32'(m_cont[ch]) * 2 + m_ps[ch] * 256;
                2'd2: m_rdata = m_per[ch];
                default: m_rdata = m_snap[ch];
            endcase
        end
        for (int c = 0; c < NCH; c++) begin
            old_cnt[c] = m_cnt[c];
            old_run[c] = m_run[c];
            ev[c] = 0;
            if (m_run[c]) begin
                if (m_psc[c] == m_ps[c]) begin
                    m_psc[c] = 0;
                    if (m_cnt[c] == 0) begin
                        m_cnt[c] = m_per[c];
                        m_to[c] = 1;
                        ev[c] = 1;
                        if (!m_cont[c]) m_run[c] = 0;
                    end else begin
                        m_cnt[c] = m_cnt[c] - 1;
                    end
                end else begin
                    m_psc[c] = (m_psc[c] + 1) % 256;
                end
            end
            m_pulse[c] = ev[c];
        end
        if (wr && ch < NCH) begin
            case (a[1:0])
                2'd0: if (!ev[ch]) m_to[ch] = 0;
                2'd1: begin
                    m_ito[ch] = d[0];
                    m_cont[ch] = d[1];
                    m_ps[ch] = d[15:8];
                    if (d[3]) m_run[ch] = 0;
                    else if (d[2] && !old_run[ch]) begin
                        m_run[ch] = 1;
                        m_psc[ch] = 0;
                    end
                end
                2'd2: begin
                    m_per[ch] = d[15:0];
                    m_cnt[ch] = d[15:0];
                    m_run[ch] = 0;
                    m_psc[ch] = 0;
                end
                default: m_snap[ch] = old_cnt[ch];
            endcase
        end
    endfunction

    task automatic cyc(input bit cs, input bit wr, input logic [3:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = !wr;
        address    = a;
        writedata  = d;
        @(posedge clk);
        model_step(reset_n, cs && wr, a, d);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] v);
        cyc(1'b1, 1'b0, a, 32'd0);
        v = readdata;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0;
        idle();
        reset_n = 1'b1;
        checks++;
        if (readdata !== 32'd0) begin
            errors++; $display("FAIL reset_readdata: got %0d expected 0", readdata);
        end
        checks++;
        if (timeout_pulse !== 3'b0 || irq_vec !== 3'b0) begin
            errors++; $display("FAIL reset_pulse_irqvec: got %b/%b expected 0/0",
                               timeout_pulse, irq_vec);
        end
        bus_rd(4'd2, v);
        checks++;
        if (v !== 32'(DEF)) begin
            errors++; $display("FAIL reset_period: got %0d expected %0d", v, DEF);
        end
        bus_rd(4'd0, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("FAIL reset_status: got %0d expected 0", v);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_continuous();
        int n;
        bus_wr(4'd6, 32'd9);
        bus_wr(4'd5, 32'h07);
        for (n = 1; n <= 200; n++) begin
            idle();
            if (timeout_pulse[1]) break;
        end
        checks++;
        if (n != (9 + 1) * (0 + 1)) begin
            errors++; $display("FAIL cont_first_timeout: got %0d clocks expected 10", n);
        end
        checks++;
        if (irq !== 1'b1 || irq_vec !== 3'b010) begin
            errors++; $display("FAIL cont_irq_rise: got irq=%b vec=%b expected 1/010",
                               irq, irq_vec);
        end
        for (int k = 0; k < 2; k++) begin
            for (n = 1; n <= 200; n++) begin
                idle();
                if (timeout_pulse[1]) break;
            end
            checks++;
            if (n != 10) begin
                errors++; $display("FAIL cont_interval: got %0d clocks expected 10", n);
            end
        end
        bus_wr(4'd4, 32'd0);
        checks++;
        if (irq_vec[1] !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL cont_to_clear: got vec=%b irq=%b expected 0/0",
                               irq_vec[1], irq);
        end
        for (n = 1; n <= 200; n++) begin
            idle();
            if (timeout_pulse[1]) break;
        end
        checks++;
        if (n != 9 || irq_vec[1] !== 1'b1) begin
            errors++; $display("FAIL cont_to_reset: got %0d clocks vec=%b expected 9/1",
                               n, irq_vec[1]);
        end
        bus_wr(4'd5, 32'h0B);
        bus_wr(4'd4, 32'd0);
    endtask

    task automatic test_one_shot();
        int n;
        int extra;
        logic [31:0] v;
        bus_wr(4'd10, 32'd4);
        bus_wr(4'd9, 32'h0304);
        for (n = 1; n <= 400; n++) begin
            idle();
            if (timeout_pulse[2]) break;
        end
        checks++;
        if (n != (4 + 1) * (3 + 1)) begin
            errors++; $display("FAIL oneshot_timeout: got %0d clocks expected 20", n);
        end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            idle();
            if (timeout_pulse[2]) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL oneshot_extra_pulses: got %0d expected 0", extra);
        end
        bus_rd(4'd8, v);
        checks++;
        if (v !== 32'h1) begin
            errors++; $display("FAIL oneshot_status: got %0h expected 1", v);
        end
        bus_wr(4'd11, 32'd0);
        bus_rd(4'd11, v);
        checks++;
        if (v !== 32'd4) begin
            errors++; $display("FAIL oneshot_counter: got %0d expected 4", v);
        end
        bus_rd(4'd9, v);
        checks++;
        if (v !== 32'h0300) begin
            errors++; $display("FAIL oneshot_control_read: got %0h expected 300", v);
        end
    endtask

    task automatic test_snap_stop();
        logic [31:0] v;
        bus_wr(4'd2, 32'd100);
        bus_wr(4'd1, 32'h06);
        repeat (43) idle();
        bus_wr(4'd3, 32'd0);
        bus_rd(4'd3, v);
        checks++;
        if (v !== 32'd57) begin
            errors++; $display("FAIL snap_value: got %0d expected 57", v);
        end
        bus_wr(4'd1, 32'h0A);
        bus_rd(4'd0, v);
        checks++;
        if (v[1] !== 1'b0) begin
            errors++; $display("FAIL stop_run: got %b expected 0", v[1]);
        end
        bus_wr(4'd1, 32'h0E);
        bus_rd(4'd0, v);
        checks++;
        if (v[1] !== 1'b0) begin
            errors++; $display("FAIL start_stop_run: got %b expected 0", v[1]);
        end
        repeat (20) idle();
        bus_wr(4'd3, 32'd0);
        bus_rd(4'd3, v);
        checks++;
        if (v !== 32'(m_snap[0]) || m_snap[0] >= 57) begin
            errors++; $display("FAIL stop_hold: got %0d expected %0d", v, m_snap[0]);
        end
    endtask

    task automatic test_status_race();
        logic [31:0] v;
        bus_wr(4'd6, 32'd9);
        bus_wr(4'd4, 32'd0);
        bus_wr(4'd5, 32'h07);
        repeat (9) idle();
        checks++;
        if (irq_vec[1] !== 1'b0) begin
            errors++; $display("FAIL race_pre_to: got %b expected 0", irq_vec[1]);
        end
        bus_wr(4'd4, 32'd0);
        checks++;
        if (timeout_pulse[1] !== 1'b1 || irq_vec[1] !== 1'b1) begin
            errors++; $display("FAIL race_event_wins: got pulse=%b vec=%b expected 1/1",
                               timeout_pulse[1], irq_vec[1]);
        end
        repeat (4) idle();
        bus_wr(4'd6, 32'd25);
        bus_rd(4'd4, v);
        checks++;
        if (v[1] !== 1'b0) begin
            errors++; $display("FAIL period_write_run: got %b expected 0", v[1]);
        end
        bus_wr(4'd7, 32'd0);
        bus_rd(4'd7, v);
        checks++;
        if (v !== 32'd25) begin
            errors++; $display("FAIL period_write_load: got %0d expected 25", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic [31:0] exp;
        bus_wr(4'd2, 32'd30);
        bus_wr(4'd1, 32'h07);
        bus_wr(4'd6, 32'd11);
        bus_wr(4'd5, 32'h07);
        bus_wr(4'd10, 32'd7);
        bus_wr(4'd9, 32'h0107);
        repeat (15) idle();
        reset_n = 1'b0;
        idle();
        reset_n = 1'b1;
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0 || irq_vec !== 3'b0 || timeout_pulse !== 3'b0)
        begin
            errors++; $display("FAIL midreset_outputs: got rd=%0h irq=%b vec=%b pulse=%b expected 0",
                               readdata, irq, irq_vec, timeout_pulse);
        end
        for (int c = 0; c < NCH; c++) begin
            for (int off = 0; off < 4; off++) begin
                bus_rd(4'(c * 4 + off), v);
                exp = (off == 2) ? 32'(DEF) : 32'd0;
                checks++;
                if (v !== exp) begin
                    errors++; $display("FAIL midreset_reg ch%0d off%0d: got %0d expected %0d",
                                       c, off, v, exp);
                end
            end
        end
        for (int a = 12; a < 16; a++) begin
            bus_rd(4'(a), v);
            checks++;
            if (v !== 32'd0) begin
                errors++; $display("FAIL bad_channel_read a%0d: got %0h expected 0", a, v);
            end
        end
        bus_wr(4'd14, 32'd5);
        bus_wr(4'd13, 32'h07);
        bus_wr(4'd12, 32'd0);
        bus_wr(4'd15, 32'd0);
        repeat (10) idle();
        for (int c = 0; c < NCH; c++) begin
            bus_rd(4'(c * 4 + 2), v);
            checks++;
            if (v !== 32'(DEF)) begin
                errors++; $display("FAIL bad_channel_write_period ch%0d: got %0d expected %0d",
                                   c, v, DEF);
            end
            bus_rd(4'(c * 4), v);
            checks++;
            if (v !== 32'd0) begin
                errors++; $display("FAIL bad_channel_write_status ch%0d: got %0h expected 0",
                                   c, v);
            end
        end
        bus_rd(4'd14, v);
        checks++;
        if (v !== 32'd0) begin
            errors++; $display("FAIL bad_channel_readback: got %0h expected 0", v);
        end
    endtask

    task automatic test_random();
        logic [3:0]  a;
        logic [31:0] d;
        bit cs;
        bit wr;
        logic [NCH-1:0] exp_pulse;
        logic [NCH-1:0] exp_vec;
        for (int i = 0; i < 4000; i++) begin
            a  = 4'($urandom_range(0, 15));
            cs = $urandom_range(0, 3) != 0;
            wr = cs && ($urandom_range(0, 2) == 0);
            d  = $urandom;
            if (a[1:0] == 2'd1) d[15:8] = 8'($urandom_range(0, 2));
            if (a[1:0] == 2'd2) d[15:0] = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
            cyc(cs, wr, a, d);
            reset_n = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                exp_pulse[c] = m_pulse[c];
                exp_vec[c]   = m_to[c] & m_ito[c];
            end
            checks++;
            if (readdata !== m_rdata) begin
                errors++; $display("FAIL rand_readdata cyc%0d: got %0h expected %0h",
                                   i, readdata, m_rdata);
            end
            checks++;
            if (timeout_pulse !== exp_pulse) begin
                errors++; $display("FAIL rand_pulse cyc%0d: got %b expected %b",
                                   i, timeout_pulse, exp_pulse);
            end
            checks++;
            if (irq_vec !== exp_vec || irq !== (|exp_vec)) begin
                errors++; $display("FAIL rand_irq cyc%0d: got %b/%b expected %b/%b",
                                   i, irq_vec, irq, exp_vec, |exp_vec);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        test_reset();
        test_continuous();
        test_one_shot();
        test_snap_stop();
        test_status_race();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/system_timer_mc.md
Name: system_timer_mc

Overview:
Multi-channel interval timer on an Avalon-MM slave. It is the parametrised successor of the single-channel system timer. It provides NUM_CH independent down-counters with configurable width, a per-channel 8-bit prescaler, one-shot or continuous mode, snapshot capture, per-channel timeout pulses, and a combined interrupt. It sits on the system interconnect beside the CPU as a general-purpose tick and delay source.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
COUNT_W, 32, counter/period width in bits (8..32, <= DATA_W)
DATA_W, 32, Avalon data width
ADDR_W, 4, word address width; NUM_CH*4 <= 2**ADDR_W
DEFAULT_PERIOD, 49999, reset value of every PERIOD register and counter

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock, synchronous, active-low
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
address  in  ADDR_W  word address; channel = address[ADDR_W-1:2], offset = address[1:0]
writedata  in  DATA_W  write data
readdata  out  DATA_W  registered read data
irq  out  1  OR over channels of (TO & ITO)
irq_vec  out  NUM_CH  per-channel (TO & ITO)
timeout_pulse  out  NUM_CH  one-cycle pulse per channel timeout event

Behaviour:
- Reset (reset_n low at clk edge) loads: counter = PERIOD = DEFAULT_PERIOD, CONTROL = 0, TO = 0, RUN = 0, snapshot = 0, prescaler = 0, readdata = 0, timeout_pulse = 0. irq and irq_vec derive from registers, so both read 0 after reset.
- Reset asserted mid-count aborts the count. No pending event survives reset.
- Register map per channel (offset):
  - 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START (write-only strobe), bit3 STOP (write-only strobe), bits[15:8] PS. Only bit0, bit1 and PS are stored. Bits 2 and 3 read 0.
  - 2 PERIOD: COUNT_W bits, zero-extended on read.
  - 3 SNAP: any write captures the counter in the same cycle. Reads return the captured value.
- Reads: readdata is registered 1 cycle after address is presented, every cycle regardless of chipselect. Unused bits and nonexistent channels read 0. Writes to nonexistent channels are ignored.
- Prescaler: per-channel counter ps_cnt. While RUN, tick = (ps_cnt == PS). On tick ps_cnt resets to 0, otherwise it increments. PS = 0 gives a tick every clock.
- Counting on each tick while RUN:
  - If counter == 0: counter <= PERIOD, TO <= 1, timeout_pulse high for that cycle. If CONT = 0, RUN <= 0.
  - Otherwise counter decrements.
  - Result: one timeout period = (PERIOD+1)*(PS+1) clocks.
- START with RUN=0: RUN <= 1 and ps_cnt <= 0. The counter resumes from its current value.
- START with RUN=1: no effect.
- STOP: RUN <= 0. The counter holds its value.
- START and STOP in the same write: STOP wins.
- PERIOD write: PERIOD updates, the counter loads the new value on the next clock, RUN <= 0, ps_cnt <= 0.
- Timeout event coinciding with a STATUS write: the event wins and TO stays 1.
- PERIOD = 0 with CONT = 1: a timeout fires on every tick.
- The counter never wraps below 0. Reload is the only transition away from 0.
- Channels are fully independent. Simultaneous events on several channels each set their own TO. irq is combinational from the registered TO and ITO.

Test Plan:
1. Reset, then read ch0 PERIOD -> readdata = 49999 one cycle after the address. Read ch0 STATUS -> 0. irq = 0.
2. ch1: PERIOD = 9, CONTROL = 0x07 (ITO, CONT, START) -> timeout_pulse[1] every 10 clocks. irq and irq_vec[1] rise at the first timeout. A STATUS write clears TO, and TO re-sets at the next timeout.
3. ch2: PERIOD = 4, CONTROL = 0x0304 (PS = 3, one-shot, START) -> a single timeout after 20 clocks, then RUN = 0 and counter = 4. No further pulses occur.
4. ch0 running with PERIOD = 100. Write SNAP at counter value 57 -> SNAP reads 57. Write CONTROL = 0x08 (STOP) -> RUN = 0 and the counter holds. Write 0x0C (START+STOP) -> RUN stays 0.
5. Time a STATUS write to land on the exact timeout clock -> TO remains 1. In a separate run, write PERIOD mid-count -> RUN = 0 and counter = new PERIOD on the next clock.
6. Assert reset_n low for one clock mid-count on all channels -> every register returns to its reset value. Read an address beyond NUM_CH*4 -> 0, and writes to it change nothing.
